// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Holds the register-file geometry, the FSM state type and the request bundle.
package regfile_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        INIT,
        RUN
    } rf_arb_state_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // Writes to x0 are swallowed: the handshake completes but nothing commits.
    function automatic logic is_x0(input logic [REG_AW-1:0] rd);
        return rd == '0;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Two writeback requester channels (valid/rd/data with ready back).
// The master modport is the requester side, the slave modport the arbiter.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic              wb0_valid;
    logic [REG_AW-1:0] wb0_rd;
    logic [XLEN-1:0]   wb0_data;
    logic              wb0_ready;

    logic              wb1_valid;
    logic [REG_AW-1:0] wb1_rd;
    logic [XLEN-1:0]   wb1_data;
    logic              wb1_ready;

    modport master (
        output wb0_valid, wb0_rd, wb0_data,
        output wb1_valid, wb1_rd, wb1_data,
        input  wb0_ready, wb1_ready
    );

    modport slave (
        input  wb0_valid, wb0_rd, wb0_data,
        input  wb1_valid, wb1_rd, wb1_data,
        output wb0_ready, wb1_ready
    );

endinterface

// File: rtl/wb_pick.sv
// Two-way writeback grant: a lone requester wins, a contended cycle
// goes to port 0 unless port 1 has waited the maximum number of grants.
module wb_pick (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       starve_at_limit,
    output logic [1:0] grant
);

    // Mutually exclusive request patterns; idle leaves the grant empty.
    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            valid0 && valid1 && starve_at_limit:  grant = 2'b10;
            valid0 && valid1 && !starve_at_limit: grant = 2'b01;
            valid0 && !valid1:                    grant = 2'b01;
            !valid0 && valid1:                    grant = 2'b10;
            default:                              grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register file write port: zero-clears x1..x31 after reset or
// clear, then arbitrates two writeback requesters with starvation relief.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    regfile_wb_arbiter_if.slave wb,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              busy,
    output logic              init_done
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NUM_REGS - 1);
    localparam logic [REG_AW-1:0] FIRST_IDX = REG_AW'(1);

    rf_arb_state_t     state_q, state_d;
    logic [REG_AW-1:0] idx_q, idx_d;
    logic              we_q, we_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;

    logic              arb_en;
    logic [1:0]        grant;
    logic              accept;
    wb_req_t           sel;

    assign arb_en = (state_q == RUN) && !clear;

    wb_pick u_pick (
        .valid0          (wb.wb0_valid),
        .valid1          (wb.wb1_valid),
        .starve_at_limit (cnt_q == LIM),
        .grant           (grant)
    );

    assign wb.wb0_ready = arb_en & grant[0];
    assign wb.wb1_ready = arb_en & grant[1];
    assign accept       = wb.wb0_ready | wb.wb1_ready;

    // Route the granted requester's payload toward the write port.
    always_comb begin
        sel.rd   = wb.wb0_rd;
        sel.data = wb.wb0_data;
        if (grant[1]) begin
            sel.rd   = wb.wb1_rd;
            sel.data = wb.wb1_data;
        end
    end

    // Next state: clear walk, then one granted write per cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        unique case (state_q)
            INIT: begin
                we_d    = 1'b1;
                rd_d    = idx_q;
                wdata_d = '0;
                idx_d   = idx_q + 1'b1;
                cnt_d   = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                    idx_d   = FIRST_IDX;
                    done_d  = 1'b1;
                end
            end
            RUN: begin
                if (clear) begin
                    state_d = INIT;
                    idx_d   = FIRST_IDX;
                    cnt_d   = '0;
                end else begin
                    if (accept && !is_x0(sel.rd)) begin
                        we_d    = 1'b1;
                        rd_d    = sel.rd;
                        wdata_d = sel.data;
                    end
                    if (wb.wb1_ready || !wb.wb1_valid) begin
                        cnt_d = '0;
                    end else if (wb.wb0_ready && cnt_q != LIM) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // State and registered write-port outputs; reset drops any write in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            idx_q   <= FIRST_IDX;
            we_q    <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign rf_we     = we_q;
    assign rf_rd     = rd_q;
    assign rf_wdata  = wdata_q;
    assign busy      = (state_q == INIT);
    assign init_done = done_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: clear walk, grants, starvation,
// x0 writes, clear restart and asynchronous reset during the walk.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        init_done;
    logic        g1;

    int n_chk;
    int n_fail;

    regfile_wb_arbiter_if wb ();

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .wb        (wb),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .busy      (busy),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset_n = 1'b0;
        clear   = 1'b0;
        wb.wb0_valid = 1'b1;
        wb.wb0_rd    = 5'd7;
        wb.wb0_data  = 32'h77;
        wb.wb1_valid = 1'b0;
        wb.wb1_rd    = 5'd0;
        wb.wb1_data  = 32'h0;

        #2;
        chk("rst_we", rf_we, 0);
        chk("rst_rd", rf_rd, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_busy", busy, 1);
        chk("rst_done", init_done, 0);
        chk("rst_rdy0", wb.wb0_ready, 0);

        #5;
        reset_n = 1'b1;

        for (int k = 1; k <= 31; k++) begin
            step();
            chk("walk_we", rf_we, 1);
            chk("walk_rd", rf_rd, k);
            chk("walk_wdata", rf_wdata, 0);
            if (k < 31) begin
                chk("walk_busy", busy, 1);
                chk("walk_rdy0", wb.wb0_ready, 0);
            end else begin
                chk("walk_end_busy", busy, 0);
                chk("walk_end_done", init_done, 1);
                chk("first_rdy0", wb.wb0_ready, 1);
            end
        end

        step();
        chk("first_wr_we", rf_we, 1);
        chk("first_wr_rd", rf_rd, 7);
        chk("first_wr_data", rf_wdata, 32'h77);
        wb.wb0_rd   = 5'd5;
        wb.wb0_data = 32'hDEADBEEF;
        #1;
        chk("p0_rdy", wb.wb0_ready, 1);
        chk("p0_rdy1", wb.wb1_ready, 0);

        step();
        chk("p0_we", rf_we, 1);
        chk("p0_rd", rf_rd, 5);
        chk("p0_data", rf_wdata, 32'hDEADBEEF);
        wb.wb0_valid = 1'b0;

        step();
        chk("idle_we", rf_we, 0);
        chk("idle_rd_hold", rf_rd, 5);
        chk("idle_data_hold", rf_wdata, 32'hDEADBEEF);

        wb.wb0_valid = 1'b1;
        wb.wb0_rd    = 5'd2;
        wb.wb0_data  = 32'hA0A0A0A0;
        wb.wb1_valid = 1'b1;
        wb.wb1_rd    = 5'd3;
        wb.wb1_data  = 32'hB1B1B1B1;
        #1;
        for (int i = 0; i < 10; i++) begin
            g1 = (i % 5 == 4);
            chk("starve_rdy0", wb.wb0_ready, !g1);
            chk("starve_rdy1", wb.wb1_ready, g1);
            step();
            chk("starve_we", rf_we, 1);
            chk("starve_rd", rf_rd, g1 ? 3 : 2);
            chk("starve_data", rf_wdata, g1 ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
        end

        wb.wb0_valid = 1'b0;
        wb.wb1_rd    = 5'd0;
        wb.wb1_data  = 32'h1234;
        #1;
        chk("x0_rdy1", wb.wb1_ready, 1);
        chk("x0_rdy0", wb.wb0_ready, 0);
        step();
        wb.wb1_valid = 1'b0;
        chk("x0_we", rf_we, 0);
        chk("x0_rd_hold", rf_rd, 3);

        wb.wb0_valid = 1'b1;
        wb.wb0_rd    = 5'd2;
        wb.wb1_valid = 1'b1;
        wb.wb1_rd    = 5'd3;
        clear        = 1'b1;
        #1;
        chk("clr_rdy0", wb.wb0_ready, 0);
        chk("clr_rdy1", wb.wb1_ready, 0);
        step();
        clear = 1'b0;
        chk("clr_we", rf_we, 0);
        chk("clr_busy", busy, 1);
        chk("clr_done_sticky", init_done, 1);
        chk("clr_walk_rdy0", wb.wb0_ready, 0);
        for (int k = 1; k <= 31; k++) begin
            step();
            chk("rewalk_we", rf_we, 1);
            chk("rewalk_rd", rf_rd, k);
            chk("rewalk_wdata", rf_wdata, 0);
            if (k < 31) begin
                chk("rewalk_rdy0", wb.wb0_ready, 0);
                chk("rewalk_rdy1", wb.wb1_ready, 0);
            end else begin
                chk("rewalk_busy", busy, 0);
                chk("resume_rdy0", wb.wb0_ready, 1);
                chk("resume_rdy1", wb.wb1_ready, 0);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("resume_seq_rdy0", wb.wb0_ready, i < 4);
            chk("resume_seq_rdy1", wb.wb1_ready, i == 4);
        end

        wb.wb0_valid = 1'b0;
        wb.wb1_valid = 1'b0;
        clear        = 1'b1;
        #1;
        step();
        clear = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
        end
        chk("mid_rd16", rf_rd, 16);
        chk("mid_busy", busy, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_we", rf_we, 0);
        chk("async_rd", rf_rd, 0);
        chk("async_wdata", rf_wdata, 0);
        chk("async_done", init_done, 0);
        chk("async_busy", busy, 1);
        step();
        chk("hold_rst_we", rf_we, 0);
        reset_n = 1'b1;
        step();
        chk("restart_we", rf_we, 1);
        chk("restart_rd", rf_rd, 1);
        chk("restart_busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Sequences the 32x32 general-purpose register file's single write port. After reset it walks x1..x31 writing zero (hardware clear), then shares the write port between two writeback requesters: port 0 is the core's ALU/immediate writeback, port 1 is the load/long-latency unit. It sits between the writeback sources and the register file's RegWrite/rd/Write_Data inputs and replaces direct drive of those pins.

## Interface
- STARVE_LIMIT, 4, max consecutive port-0 grants while port 1 waits; legal range 1..15
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  single-cycle pulse, re-runs the zero-clear walk
- wb0_valid  in  1  port 0 write request
- wb0_rd  in  5  port 0 destination register
- wb0_data  in  32  port 0 write data
- wb0_ready  out  1  port 0 accepted this cycle
- wb1_valid, wb1_rd, wb1_data, wb1_ready  same as port 0, for port 1
- rf_we  out  1  to register file RegWrite
- rf_rd  out  5  to register file rd
- rf_wdata  out  32  to register file Write_Data
- busy  out  1  clear walk in progress
- init_done  out  1  sticky high after the first completed walk; cleared only by reset

## Operation
- States: INIT, RUN. Reset values: state=INIT, idx=1, rf_we=0, rf_rd=0, rf_wdata=0, starve_cnt=0, init_done=0. busy=(state==INIT); wbX_ready=0 during reset.
- INIT: each cycle issues a write of 0 to idx and increments idx. When idx==31 is issued: state->RUN, init_done<=1. Both readies are 0 throughout. clear is ignored in INIT.
- RUN with clear=1: no grant that cycle (both readies 0). state->INIT, idx=1. The walk restarts next cycle.
- RUN arbitration (combinational readies, gated by valid):
  - only one port valid: grant it.
  - both valid: grant port 1 if starve_cnt==STARVE_LIMIT, else grant port 0.
- starve_cnt:
  - +1 when port 0 is granted while wb1_valid.
  - ->0 when port 1 is granted or wb1_valid is low.
  - saturates at STARVE_LIMIT.
- Handshake: transfer occurs when valid&&ready. A requester holds valid, rd and data stable until accepted. Valid must not depend on ready.
- x0: a granted request with rd==0 is accepted (ready=1) but produces rf_we=0. It still counts as a grant for starve_cnt.
- rf_rd/rf_wdata on a non-write cycle hold their last value. rf_we=0.

## Timing
- Outputs rf_we/rf_rd/rf_wdata are registered.
- Accept in cycle t -> rf_we=1 with that rd/data in cycle t+1. The register file commits at the end of t+1.
- Clear walk: first zero write visible in the 1st cycle after reset_n rises. rd=31 is visible in cycle 31. busy falls and init_done rises in cycle 31, so the first ready is possible in cycle 31.
- Throughput: one write per cycle. Back-to-back grants have no bubble.
- Async reset mid-walk or mid-transfer: all state returns to reset values immediately. A pending accepted write in flight is dropped (rf_we=0).

## Structure
- regfile_pkg:
  - XLEN=32, REG_AW=5, NUM_REGS=32.
  - typedef enum logic {INIT, RUN} rf_arb_state_t.
  - typedef struct {rd, data} wb_req_t.
- Sub-module wb_pick: combinational two-way grant with the starve rule. Inputs: valids and starve_at_limit. Outputs: grant vector.
- starve_cnt width: $clog2(STARVE_LIMIT+1).

## Test plan
- Reset release, no requests -> rf_we=1 for 31 cycles with rf_rd=1..31 and rf_wdata=0. busy low and init_done high from cycle 31. No ready before cycle 31.
- RUN, wb0 valid rd=5 data=0xDEADBEEF -> wb0_ready same cycle. Next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF.
- Both ports valid continuously, STARVE_LIMIT=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1…
- wb1 valid rd=0 data=0x1234 alone -> wb1_ready=1. Next cycle rf_we=0.
- clear pulse while both valid -> no ready that cycle. A 31-cycle zero walk follows, then arbitration resumes with starve_cnt=0.
- reset_n asserted in the middle of the walk (idx=17) -> outputs 0 immediately. After release the walk restarts at rd=1.
